blit_bus_responder: RTL and testbench

//  Bus target for the blitter master port. Accepts mreq/read/width/justify/address requests,

---
 rtl/blit_bus_pkg.sv | 46 ++++
 rtl/blit_bus_responder_if.sv | 46 ++++
 rtl/blit_lane_align.sv | 36 +++
 rtl/blit_bus_responder.sv | 174 +++++++++++++++++
 tb/tb_blit_bus_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/blit_bus_pkg.sv
// rtl/blit_bus_pkg.sv - shared types, width codes and lane helpers for the blitter bus responder
//
// Purpose: width code constants, FSM state type and the byte-lane helper functions
//          used by both the request capture path and the read-data alignment path.
// Ports:   none (package)

package blit_bus_pkg;

  localparam logic [3:0] W8  = 4'd0;
  localparam logic [3:0] W16 = 4'd1;
  localparam logic [3:0] W32 = 4'd2;
  localparam logic [3:0] W64 = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RESP,
    DONE
  } state_t;

  // Byte offset inside the phrase; low address bits below the transfer size
  // are dropped so every access is naturally aligned. Codes above W64 act as 64b.
  function automatic logic [2:0] size_to_off(input logic [3:0] width, input logic [2:0] addr_lo);
    logic [2:0] off;
    case (width)
      W8:      off = addr_lo;
      W16:     off = {addr_lo[2:1], 1'b0};
      W32:     off = {addr_lo[2], 2'b00};
      default: off = 3'd0;
    endcase
    return off;
  endfunction

  function automatic logic [7:0] size_to_be(input logic [3:0] width, input logic [2:0] addr_lo);
    logic [7:0] m;
    case (width)
      W8:      m = 8'h01;
      W16:     m = 8'h03;
      W32:     m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << size_to_off(width, addr_lo);
  endfunction

endpackage

// File: rtl/blit_bus_responder_if.sv
// rtl/blit_bus_responder_if.sv - blitter bus request/response and memory port bundle
//
// Purpose: groups the blitter master handshake and the phrase-wide memory port.
// Ports:   slave  - responder view (takes requests, drives memory port)
//          master - blitter/memory-model view (drives requests, answers memory port)

interface blit_bus_responder_if #(
  parameter int AW = 24
);

  logic          mreq;
  logic          read;
  logic [3:0]    width;
  logic          justify;
  logic [AW-1:0] address;
  logic [63:0]   wdata;
  logic          ack;
  logic [63:0]   rdata;
  logic          rvalid;
  logic          err;
  logic          busy;

  logic          mem_req;
  logic          mem_we;
  logic [AW-4:0] mem_addr;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wdata;
  logic          mem_rdy;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;

  modport slave (
    input  mreq, read, width, justify, address, wdata,
    input  mem_rdy, mem_rvalid, mem_rdata,
    output ack, rdata, rvalid, err, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output mreq, read, width, justify, address, wdata,
    output mem_rdy, mem_rvalid, mem_rdata,
    input  ack, rdata, rvalid, err, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/blit_lane_align.sv
// rtl/blit_lane_align.sv - byte-enable generation and read-data justify/mask
//
// Purpose: combinational lane logic shared by request capture and read return.
// Ports:   width, addr_lo - transfer size code and address[2:0]
//          justify        - 1: shift selected bytes down to bit 0; 0: keep lanes
//          din            - phrase data from memory
//          be             - byte enables for the access
//          dout           - aligned/masked read data

module blit_lane_align
  import blit_bus_pkg::*;
(
  input  logic [3:0]  width,
  input  logic [2:0]  addr_lo,
  input  logic        justify,
  input  logic [63:0] din,
  output logic [7:0]  be,
  output logic [63:0] dout
);

  logic [2:0]  off;
  logic [63:0] lane_mask;
  logic [63:0] size_mask;

  always_comb begin
    be  = size_to_be(width, addr_lo);
    off = size_to_off(width, addr_lo);
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{be[i]}};
    end
    // Moving the lane mask down by the offset gives an S-byte mask at bit 0.
    size_mask = lane_mask >> {off, 3'b000};
    dout = justify ? ((din >> {off, 3'b000}) & size_mask) : (din & lane_mask);
  end

endmodule

// File: rtl/blit_bus_responder.sv
// rtl/blit_bus_responder.sv - blitter bus target bridging to a 64-bit phrase memory port
//
// Purpose: captures blitter requests, acks them, issues one memory access and
//          returns read data (or err on timeout).
// Ports:   sys_clk, xreset_n - clock and synchronous active-low reset
//          bus (slave)       - blitter request/response and memory port

module blit_bus_responder
  import blit_bus_pkg::*;
#(
  parameter int AW      = 24,
  parameter int TIMEOUT = 64
) (
  input  logic                   sys_clk,
  input  logic                   xreset_n,
  blit_bus_responder_if.slave    bus
);

  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          read_q, read_d;
  logic          justify_q, justify_d;
  logic [3:0]    width_q, width_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic [63:0]   data_q, data_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [63:0]   rdata_q, rdata_d;

  logic          sel_live;
  logic [3:0]    al_width;
  logic [2:0]    al_lo;
  logic [7:0]    al_be;
  logic [63:0]   al_dout;

  // In IDLE the aligner looks at the live request to produce byte enables;
  // afterwards it works on the captured fields to shape returning read data.
  assign sel_live = (state_q == IDLE);
  assign al_width = sel_live ? bus.width : width_q;
  assign al_lo    = sel_live ? bus.address[2:0] : addr_q[2:0];

  blit_lane_align u_align (
    .width   (al_width),
    .addr_lo (al_lo),
    .justify (justify_q),
    .din     (bus.mem_rdata),
    .be      (al_be),
    .dout    (al_dout)
  );

  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    justify_d = justify_q;
    width_d   = width_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = 64'd0;

    unique case (state_q)
      IDLE: begin
        if (bus.mreq) begin
          read_d    = bus.read;
          justify_d = bus.justify;
          width_d   = bus.width;
          addr_d    = bus.address;
          wdata_d   = bus.wdata;
          be_d      = al_be;
          ack_d     = 1'b1;
          cnt_d     = 7'd0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // mem_rdy is tested first so it beats a same-cycle timeout.
        if (bus.mem_rdy) begin
          cnt_d   = 7'd0;
          state_d = read_q ? RDWAIT : DONE;
        end else if (cnt_q == TMO_LAST) begin
          err_d    = 1'b1;
          rvalid_d = read_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      RDWAIT: begin
        if (bus.mem_rvalid) begin
          data_d  = al_dout;
          state_d = RESP;
        end else if (cnt_q == TMO_LAST) begin
          err_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      RESP: begin
        rvalid_d = 1'b1;
        rdata_d  = data_q;
        state_d  = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Responses are registered, so busy stays up through the cycle that
    // presents rvalid/err and drops on the one after.
    busy_d = (state_d != IDLE) | rvalid_d | err_d;
  end

  always_ff @(posedge sys_clk) begin
    if (!xreset_n) begin
      state_q   <= IDLE;
      read_q    <= 1'b0;
      justify_q <= 1'b0;
      width_q   <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 64'd0;
      be_q      <= 8'd0;
      data_q    <= 64'd0;
      cnt_q     <= 7'd0;
      ack_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= 64'd0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      justify_q <= justify_d;
      width_q   <= width_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) & ~read_q;
  assign bus.mem_addr  = addr_q[AW-1:3];
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_blit_bus_responder.sv
// tb/tb_blit_bus_responder.sv - self-checking bench for blit_bus_responder

module tb_blit_bus_responder;

  localparam int AW = 24;

  typedef struct {
    logic          read;
    logic [3:0]    width;
    logic          justify;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    logic [63:0]   mdata;
    logic [7:0]    exp_be;
    logic [AW-4:0] exp_maddr;
    logic [63:0]   exp_rdata;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  logic sys_clk  = 1'b0;
  logic xreset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic rdy_en    = 1'b1;
  logic rvalid_en = 1'b1;
  logic force_rv  = 1'b0;
  logic pend = 1'b0, l_rdy = 1'b0, l_req = 1'b0, l_we = 1'b0, l_rv = 1'b0, l_rst = 1'b0;

  int    rv_cnt = 0;
  resp_t sb_q[$];
  vec_t  vecs[9];

  blit_bus_responder_if #(.AW(AW)) bus ();

  blit_bus_responder #(.AW(AW), .TIMEOUT(64)) dut (
    .sys_clk  (sys_clk),
    .xreset_n (xreset_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  // Memory model: accepts a request on the cycle it sees it; read data returns
  // the cycle after acceptance while rvalid_en is set.
  initial begin
    bus.mem_rdy    = 1'b0;
    bus.mem_rvalid = 1'b0;
    forever begin
      @(negedge sys_clk);
      #2;
      if (!l_rst) pend = 1'b0;
      else begin
        if (l_rv) pend = 1'b0;
        if (l_rdy && l_req && !l_we) pend = 1'b1;
      end
      bus.mem_rdy    = rdy_en && bus.mem_req;
      bus.mem_rvalid = force_rv || (rvalid_en && pend);
      l_rdy = bus.mem_rdy; l_req = bus.mem_req; l_we = bus.mem_we;
      l_rv  = bus.mem_rvalid; l_rst = xreset_n;
    end
  end

  // Scoreboard consumer: every rvalid pops one expected response.
  initial begin
    resp_t e;
    forever begin
      @(negedge sys_clk);
      #3;
      if (bus.rvalid) begin
        rv_cnt++;
        if (sb_q.size() == 0) check("unexpected_rvalid", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("sb_rdata", bus.rdata, e.rdata);
          check("sb_err", bus.err, e.err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic rd, input logic [3:0] w, input logic j,
                           input logic [AW-1:0] a, input logic [63:0] wd, input logic [63:0] md);
    bus.mreq = 1'b1; bus.read = rd; bus.width = w; bus.justify = j;
    bus.address = a; bus.wdata = wd; bus.mem_rdata = md;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int t0, rv_at;
    rv_at = -1;
    drive_req(v.read, v.width, v.justify, v.addr, v.wdata, v.mdata);
    if (v.read) sb_q.push_back('{rdata: v.exp_rdata, err: 1'b0});
    t0 = cyc;
    tick();
    check($sformatf("v%0d_ack", idx), bus.ack, 1);
    check($sformatf("v%0d_mem_req", idx), bus.mem_req, 1);
    check($sformatf("v%0d_mem_be", idx), bus.mem_be, v.exp_be);
    check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.exp_maddr);
    check($sformatf("v%0d_mem_we", idx), bus.mem_we, !v.read);
    if (!v.read) check($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.wdata);
    bus.mreq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rvalid && rv_at < 0) rv_at = cyc - t0;
    end
    check($sformatf("v%0d_rvalid_at", idx), 64'(rv_at), v.read ? 64'd4 : 64'(-1));
    check($sformatf("v%0d_busy_idle", idx), bus.busy, 0);
    check($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
  endtask

  task automatic run_timeout(input string name, input logic rd, input logic rdy, input int exp_lat);
    int t0, e_at;
    logic rv_e, busy_e;
    e_at = -1; rv_e = 1'b0; busy_e = 1'b0;
    rdy_en = rdy; rvalid_en = 1'b0;
    drive_req(rd, 4'd0, 1'b1, 24'h000005, 64'h1, 64'h8877665544332211);
    if (rd) sb_q.push_back('{rdata: 64'd0, err: 1'b1});
    t0 = cyc;
    tick();
    bus.mreq = 1'b0;
    for (int i = 0; i < 100 && e_at < 0; i++) begin
      tick();
      if (bus.err) begin e_at = cyc - t0; rv_e = bus.rvalid; busy_e = bus.busy; end
    end
    check({name, "_err_at"}, 64'(e_at), 64'(exp_lat));
    check({name, "_rvalid_with_err"}, rv_e, rd);
    check({name, "_busy_at_err"}, busy_e, 1);
    tick();
    check({name, "_busy_after"}, bus.busy, 0);
    check({name, "_mem_req_after"}, bus.mem_req, 0);
    rdy_en = 1'b1; rvalid_en = 1'b1;
    repeat (3) tick();
    check({name, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    int t0, acks, a1, a2, rv0;
    logic err_seen;

    vecs[0] = '{1'b1, 4'd0, 1'b1, 24'h000005, 64'h0, 64'h8877665544332211, 8'h20, 21'h0, 64'h66};
    vecs[1] = '{1'b1, 4'd0, 1'b0, 24'h000005, 64'h0, 64'h8877665544332211, 8'h20, 21'h0, 64'h0000660000000000};
    vecs[2] = '{1'b0, 4'd2, 1'b0, 24'h000106, 64'hAABBCCDD11223344, 64'h0, 8'hF0, 21'h20, 64'h0};
    vecs[3] = '{1'b1, 4'd1, 1'b1, 24'h00000B, 64'h0, 64'h8877665544332211, 8'h0C, 21'h1, 64'h4433};
    vecs[4] = '{1'b1, 4'd3, 1'b1, 24'h000FFF, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 21'h1FF, 64'h0123456789ABCDEF};
    vecs[5] = '{1'b1, 4'd9, 1'b0, 24'h123450, 64'h0, 64'hDEADBEEFCAFEF00D, 8'hFF, 21'h2468A, 64'hDEADBEEFCAFEF00D};
    vecs[6] = '{1'b1, 4'd2, 1'b1, 24'h000007, 64'h0, 64'h8877665544332211, 8'hF0, 21'h0, 64'h88776655};
    vecs[7] = '{1'b0, 4'd0, 1'b0, 24'hFFFFFF, 64'h5A00000000000000, 64'h0, 8'h80, 21'h1FFFFF, 64'h0};
    vecs[8] = '{1'b1, 4'd1, 1'b0, 24'h000006, 64'h0, 64'h8877665544332211, 8'hC0, 21'h0, 64'h8877000000000000};

    bus.mreq = 1'b0; bus.read = 1'b0; bus.width = 4'd0; bus.justify = 1'b0;
    bus.address = '0; bus.wdata = 64'd0; bus.mem_rdata = 64'd0;
    xreset_n = 1'b0;
    repeat (3) tick();
    check("rst_ack", bus.ack, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_mem_be", bus.mem_be, 0);
    xreset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // mreq held high: the second ack only comes once the FSM is back in IDLE.
    drive_req(1'b1, 4'd1, 1'b1, 24'h000002, 64'h0, 64'h8877665544332211);
    sb_q.push_back('{rdata: 64'h4433, err: 1'b0});
    sb_q.push_back('{rdata: 64'h4433, err: 1'b0});
    t0 = cyc; acks = 0; a1 = -1; a2 = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ack) begin
        acks++;
        if (acks == 1) a1 = cyc - t0;
        else if (acks == 2) begin a2 = cyc - t0; bus.mreq = 1'b0; end
      end
    end
    check("held_ack1_at", 64'(a1), 1);
    check("held_ack2_at", 64'(a2), 5);
    check("held_ack_count", 64'(acks), 2);
    check("held_sb_empty", sb_q.size(), 0);

    run_timeout("wr_issue_tmo", 1'b0, 1'b0, 65);
    run_timeout("rd_issue_tmo", 1'b1, 1'b0, 65);
    run_timeout("rd_wait_tmo", 1'b1, 1'b1, 66);

    // mem_rdy arriving in the last wait cycle beats the timeout.
    rdy_en = 1'b0;
    drive_req(1'b0, 4'd3, 1'b0, 24'h000040, 64'h1122334455667788, 64'h0);
    t0 = cyc;
    tick();
    bus.mreq = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    check("rdy_win_mem_req_held", bus.mem_req, 1);
    rdy_en = 1'b1;
    err_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      err_seen = err_seen | bus.err;
    end
    check("rdy_win_no_err", err_seen, 0);
    check("rdy_win_busy_idle", bus.busy, 0);

    // Reset while waiting for read data; a late mem_rvalid must be ignored.
    rvalid_en = 1'b0;
    rv0 = rv_cnt;
    drive_req(1'b1, 4'd0, 1'b1, 24'h000005, 64'h0, 64'h8877665544332211);
    tick();
    bus.mreq = 1'b0;
    tick();
    xreset_n = 1'b0;
    tick();
    check("rst_mid_ack", bus.ack, 0);
    check("rst_mid_rvalid", bus.rvalid, 0);
    check("rst_mid_err", bus.err, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_mem_we", bus.mem_we, 0);
    check("rst_mid_rdata", bus.rdata, 0);
    check("rst_mid_mem_be", bus.mem_be, 0);
    check("rst_mid_mem_addr", bus.mem_addr, 0);
    xreset_n = 1'b1;
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    rvalid_en = 1'b1;
    repeat (6) tick();
    check("rst_mid_no_rvalid", 64'(rv_cnt - rv0), 0);
    check("rst_mid_busy_after", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
